// File: rtl/imem_uart_loader_if.sv
`default_nettype none
// ============================================================================
//  Module  : imem_uart_loader_if
//  Purpose : Bundles the UART byte stream, the core fetch address and the
//            instruction-memory write/status signals of the boot loader.
//  Rev     : 1.0  initial release
// ============================================================================
interface imem_uart_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [31:0]       cpu_addr;
    logic [31:0]       imem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    // Loader side: consumes bytes and the fetch PC, drives the memory port.
    modport master (
        input  rx_valid, rx_data, cpu_addr,
        output imem_addr, mem_we, mem_wdata, cpu_hold,
               load_done, load_err, words_loaded
    );

    // Environment side: UART, core and instruction memory.
    modport slave (
        output rx_valid, rx_data, cpu_addr,
        input  imem_addr, mem_we, mem_wdata, cpu_hold,
               load_done, load_err, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module  : imem_uart_loader
//  Purpose : UART boot loader. Parses SYNC/LEN_LO/LEN_HI framed images, packs
//            bytes little-endian into words, writes the instruction memory,
//            muxes its address with the core PC and stalls the core meanwhile.
//  Rev     : 1.0  initial release
// ============================================================================
module imem_uart_loader #(
    parameter int         DEPTH          = 1024,
    parameter int         ADDR_W         = 10,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter bit         HOLD_AT_RESET  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_uart_loader_if.master  bus
);

    localparam int                c_IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_LEN_LO    = 3'd1,
        ST_LEN_HI    = 3'd2,
        ST_DATA      = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_hold;
    logic                w_hold_next;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_len;
    logic [1:0]          r_lane;
    logic [23:0]         r_asm;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_words;
    logic [c_IDLE_W-1:0] r_idle;

    logic                w_idle_state;
    logic                w_in_frame;
    logic                w_sync;
    logic                w_timeout;
    logic [15:0]         w_len;
    logic [ADDR_W:0]     w_words_inc;
    logic                w_last_write;
    logic                w_data_take;

    assign w_idle_state = (r_state == ST_WAIT_SYNC) || (r_state == ST_DONE) ||
                          (r_state == ST_ERROR);
    assign w_in_frame   = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                          (r_state == ST_DATA);
    assign w_sync       = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    // A byte arriving in the expiry cycle beats the timeout.
    assign w_timeout    = w_in_frame && !bus.rx_valid && (r_idle == c_IDLE_LAST);
    assign w_len        = {bus.rx_data, r_len_lo};
    assign w_words_inc  = r_words + 1'b1;
    // The pulse currently on mem_we is the frame's final word.
    assign w_last_write = r_we && (32'(w_words_inc) == 32'(r_len));
    // Bytes after the final lane-3 byte are not part of the payload.
    assign w_data_take  = (r_state == ST_DATA) && bus.rx_valid && !w_last_write;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and core-hold decode.
    always_comb begin
        w_next      = r_state;
        w_hold_next = r_hold;
        case (r_state)
            ST_WAIT_SYNC, ST_DONE, ST_ERROR: begin
                if (w_sync) begin
                    w_next      = ST_LEN_LO;
                    w_hold_next = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (bus.rx_valid) begin
                    w_next = ST_LEN_HI;
                end else if (w_timeout) begin
                    w_next      = ST_ERROR;
                    w_hold_next = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    if (32'(w_len) > DEPTH) begin
                        w_next      = ST_ERROR;
                        w_hold_next = 1'b1;
                    end else if (w_len == 16'd0) begin
                        w_next      = ST_DONE;
                        w_hold_next = 1'b0;
                    end else begin
                        w_next = ST_DATA;
                    end
                end else if (w_timeout) begin
                    w_next      = ST_ERROR;
                    w_hold_next = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_last_write) begin
                    w_next      = ST_DONE;
                    w_hold_next = 1'b0;
                end else if (w_timeout) begin
                    w_next      = ST_ERROR;
                    w_hold_next = 1'b1;
                end
            end
            default: begin
                w_next = ST_WAIT_SYNC;
            end
        endcase
    end

    // Length capture, byte packing, write pulse, word and idle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold   <= HOLD_AT_RESET;
            r_len_lo <= '0;
            r_len    <= '0;
            r_lane   <= '0;
            r_asm    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_words  <= '0;
            r_idle   <= '0;
        end else begin
            r_we   <= 1'b0;
            r_hold <= w_hold_next;
            r_idle <= (w_in_frame && !bus.rx_valid) ? r_idle + 1'b1 : '0;

            if ((r_state == ST_LEN_LO) && bus.rx_valid) begin
                r_len_lo <= bus.rx_data;
            end
            if ((r_state == ST_LEN_HI) && bus.rx_valid) begin
                r_len <= w_len;
            end

            if (w_idle_state && w_sync) begin
                r_words <= '0;
                r_lane  <= '0;
            end else begin
                if (r_we) begin
                    r_words <= w_words_inc;
                end
                if (w_data_take) begin
                    case (r_lane)
                        2'd0:    r_asm[7:0]   <= bus.rx_data;
                        2'd1:    r_asm[15:8]  <= bus.rx_data;
                        2'd2:    r_asm[23:16] <= bus.rx_data;
                        default: begin
                            r_we    <= 1'b1;
                            r_wdata <= {bus.rx_data, r_asm};
                        end
                    endcase
                    r_lane <= r_lane + 1'b1;
                end
            end
        end
    end

    assign bus.imem_addr    = w_in_frame
                              ? {{(32-ADDR_W-2){1'b0}}, r_words[ADDR_W-1:0], 2'b00}
                              : bus.cpu_addr;
    assign bus.mem_we       = r_we;
    assign bus.mem_wdata    = r_wdata;
    assign bus.cpu_hold     = r_hold;
    assign bus.load_done    = (r_state == ST_DONE);
    assign bus.load_err     = (r_state == ST_ERROR);
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_imem_uart_loader
//  Purpose : Self-checking bench for the UART instruction-memory loader.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_imem_uart_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_uart_loader_if #(.ADDR_W(10)) bus ();
    imem_uart_loader_if #(.ADDR_W(10)) bus2 ();

    imem_uart_loader #(
        .DEPTH(1024), .ADDR_W(10), .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(16), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    imem_uart_loader #(
        .DEPTH(1024), .ADDR_W(10), .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(16), .HOLD_AT_RESET(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int tests = 0;
    int failed = 0;

    // Observed write transactions and hold release.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          cyc = 0;
    int          fall_cyc = -1;
    logic        prev_hold = 1'b1;

    // Expected results from the reference model.
    logic [7:0]  stim[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_words;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.imem_addr);
            obs_data.push_back(bus.mem_wdata);
            obs_cyc.push_back(cyc);
        end
        if (prev_hold === 1'b1 && bus.cpu_hold === 1'b0) fall_cyc = cyc;
        prev_hold = bus.cpu_hold;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs_clear();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        fall_cyc = -1;
    endtask

    // Frame semantics: skip junk to the first sync, read a 16-bit word count,
    // reject counts above the memory depth, else each 4 bytes form one word
    // (first byte least significant) stored at byte address 4*index.
    task automatic model();
        int i;
        int len;
        int b;
        exp_addr.delete();
        exp_data.delete();
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        i = 0;
        while (i < stim.size() && stim[i] != 8'hA5) i++;
        len = int'(stim[i+1]) + 256 * int'(stim[i+2]);
        if (len > 1024) begin
            exp_err = 1'b1;
        end else begin
            exp_done  = 1'b1;
            exp_words = len;
            for (int w = 0; w < len; w++) begin
                b = i + 3 + 4 * w;
                exp_addr.push_back(32'(4 * w));
                exp_data.push_back(32'(stim[b]) + (32'(stim[b+1]) << 8) +
                                   (32'(stim[b+2]) << 16) + (32'(stim[b+3]) << 24));
            end
        end
    endtask

    task automatic send(input int maxgap);
        foreach (stim[k]) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = stim[k];
            tick();
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(maxgap, 0)) tick();
        end
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, ".nwr"}, obs_addr.size(), exp_addr.size());
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int k = 0; k < n; k++) begin
            chk({tag, ".addr"}, obs_addr[k], exp_addr[k]);
            chk({tag, ".data"}, obs_data[k], exp_data[k]);
        end
        if (exp_addr.size() > 0 && obs_cyc.size() > 0)
            chk({tag, ".holdfall"}, fall_cyc, obs_cyc[obs_cyc.size()-1] + 1);
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".done"},  bus.load_done, exp_done);
        chk({tag, ".err"},   bus.load_err, exp_err);
        chk({tag, ".words"}, bus.words_loaded, exp_words);
        chk({tag, ".hold"},  bus.cpu_hold, !exp_done);
        bus.cpu_addr = $urandom;
        #1;
        chk({tag, ".amux"},  bus.imem_addr, bus.cpu_addr);
    endtask

    task automatic run_frame(input string tag, input int maxgap);
        model();
        obs_clear();
        send(maxgap);
        repeat (4) tick();
        check_writes(tag);
        check_status(tag);
    endtask

    initial begin
        logic [7:0] r;
        int len;

        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.cpu_addr  = 32'h0000_1234;
        bus2.rx_valid = 1'b0;
        bus2.rx_data  = '0;
        bus2.cpu_addr = 32'h0;
        repeat (3) tick();

        // Reset values.
        chk("rst.we",    bus.mem_we, 1'b0);
        chk("rst.wdata", bus.mem_wdata, 32'h0);
        chk("rst.done",  bus.load_done, 1'b0);
        chk("rst.err",   bus.load_err, 1'b0);
        chk("rst.words", bus.words_loaded, 0);
        chk("rst.hold",  bus.cpu_hold, 1'b1);
        chk("rst.amux",  bus.imem_addr, 32'h0000_1234);
        chk("rst.hold2", bus2.cpu_hold, 1'b0);
        rst_n = 1'b1;
        tick();

        // Preloaded-image variant: core runs, address follows the PC.
        bus2.cpu_addr = 32'h40;
        #1;
        chk("pre.addr40", bus2.imem_addr, 32'h40);
        for (int k = 0; k < 8; k++) begin
            tick();
            bus2.cpu_addr = $urandom;
            #1;
            chk("pre.amux", bus2.imem_addr, bus2.cpu_addr);
            chk("pre.hold", bus2.cpu_hold, 1'b0);
            chk("pre.we",   bus2.mem_we, 1'b0);
        end

        // Two-word program.
        stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("two", 0);
        chk("two.w1", obs_data.size() > 1 ? obs_data[1] : 32'hx, 32'h0010_0093);

        // Oversize length, then an empty frame.
        stim = '{8'hA5, 8'h01, 8'h04};
        run_frame("big", 0);
        stim = '{8'hA5, 8'h00, 8'h00};
        run_frame("empty", 1);

        // Timeout after 16 idle cycles.
        stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        obs_clear();
        send(0);
        repeat (15) tick();
        chk("to.before", bus.load_err, 1'b0);
        tick();
        chk("to.err",  bus.load_err, 1'b1);
        chk("to.hold", bus.cpu_hold, 1'b1);
        chk("to.nwr",  obs_addr.size(), 0);

        // Byte in the expiry cycle keeps the frame alive.
        stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        model();
        obs_clear();
        stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send(0);
        repeat (15) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h33;
        tick();
        bus.rx_valid = 1'b0;
        chk("tolast.err", bus.load_err, 1'b0);
        stim = '{8'h44};
        send(0);
        repeat (4) tick();
        check_writes("tolast");
        check_status("tolast");

        // Junk before sync.
        stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_frame("junk", 2);

        // Reset in the middle of a word.
        stim = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        obs_clear();
        send(0);
        rst_n = 1'b0;
        #1;
        chk("mrst.we",    bus.mem_we, 1'b0);
        chk("mrst.wdata", bus.mem_wdata, 32'h0);
        chk("mrst.done",  bus.load_done, 1'b0);
        chk("mrst.err",   bus.load_err, 1'b0);
        chk("mrst.words", bus.words_loaded, 0);
        chk("mrst.hold",  bus.cpu_hold, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("mrst.nwr", obs_addr.size(), 0);
        stim = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_frame("reload", 1);

        // Randomized frames with junk prefixes, gaps and sync-valued payload.
        for (int f = 0; f < 8; f++) begin
            stim.delete();
            repeat ($urandom_range(3, 0)) begin
                r = 8'($urandom_range(255, 0));
                if (r == 8'hA5) r = 8'h00;
                stim.push_back(r);
            end
            len = $urandom_range(8, 1);
            stim.push_back(8'hA5);
            stim.push_back(8'(len));
            stim.push_back(8'h00);
            repeat (4 * len) stim.push_back(8'($urandom_range(255, 0)));
            stim[stim.size() - 1 - $urandom_range(3, 0)] = 8'hA5;
            run_frame("rnd", (f % 2 == 0) ? 0 : 3);
        end

        // Full-depth frame.
        stim = '{8'hA5, 8'h00, 8'h04};
        repeat (4096) stim.push_back(8'($urandom_range(255, 0)));
        run_frame("full", 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
